// File: rtl/pwm_dac_pkg.sv
// Shared types and helpers for the PWM DAC drive stage.
package pwm_dac_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Prescaler counter width; never narrower than one bit.
    function automatic int unsigned presc_width(input int unsigned presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/pwm_dac_if.sv
// Duty-code valid/ready handshake between control logic and the PWM DAC.
interface pwm_dac_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] duty_data;
    logic             duty_valid;
    logic             duty_ready;

    modport master (output duty_data, output duty_valid, input duty_ready);
    modport slave  (input duty_data, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler: pulses tick once every PRESCALE clocks; clear restarts the count.
module pwm_tick_gen
    import pwm_dac_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = presc_width(PRESCALE);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // Every clock is a tick; the counter collapses away.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, clear};
            assign tick      = 1'b1;
        end else begin : g_div
            logic [PW-1:0] pcnt;

            assign tick = (pcnt == PW'(PRESCALE - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pcnt <= '0;
                end else if (clear || tick) begin
                    pcnt <= '0;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pwm_dac.sv
// Double-buffered fixed-period PWM generator driving an external RC low-pass.
module pwm_dac
    import pwm_dac_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    pwm_dac_if.slave   bus,
    output logic       pwm_out,
    output logic       period_start
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] shadow;
    logic             shadow_empty;
    logic             start_pend;
    logic             tick;
    logic             presc_clear;
    logic             accept;
    logic             boundary;

    // Ready comes straight from a flop so the handshake output is registered.
    assign bus.duty_ready = shadow_empty;
    assign accept         = bus.duty_valid && shadow_empty;
    assign presc_clear    = (state != RUN) || !en;
    assign boundary       = (state == RUN) && en && tick && (cnt == CNT_MAX);

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            active       <= '0;
            shadow       <= '0;
            shadow_empty <= 1'b1;
            start_pend   <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            if (accept) begin
                shadow       <= bus.duty_data;
                shadow_empty <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    start_pend <= 1'b0;
                    if (en) begin
                        state      <= RUN;
                        cnt        <= '0;
                        start_pend <= 1'b1;
                        if (!shadow_empty) begin
                            active       <= shadow;
                            shadow_empty <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!en) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        pwm_out      <= 1'b0;
                        period_start <= 1'b0;
                        start_pend   <= 1'b0;
                    end else begin
                        pwm_out      <= (cnt < active);
                        period_start <= start_pend;
                        start_pend   <= boundary;
                        if (tick) begin
                            cnt <= cnt + WIDTH'(1);
                        end
                        // A code accepted on this same edge stays in shadow.
                        if (boundary && !shadow_empty) begin
                            active       <= shadow;
                            shadow_empty <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
